// File: rtl/aes_key_sched_pkg.sv
// Shared AES key-schedule definitions: key-mode encodings, FSM states,
// Nk/Nr lookups, the Rcon seed and the GF(2^8) byte/word helpers.
package aes_key_sched_pkg;

    typedef enum logic [1:0] {
        KEY_MODE_128     = 2'd0,
        KEY_MODE_192     = 2'd1,
        KEY_MODE_256     = 2'd2,
        KEY_MODE_ILLEGAL = 2'd3
    } key_mode_e;

    typedef enum logic {
        ST_IDLE = 1'b0,
        ST_RUN  = 1'b1
    } state_e;

    localparam logic [7:0] RCON_INIT = 8'h01;

    // Key length in words for a key mode.
    function automatic logic [3:0] nk_of(input logic [1:0] mode);
        case (mode)
            KEY_MODE_128: return 4'd4;
            KEY_MODE_192: return 4'd6;
            KEY_MODE_256: return 4'd8;
            default:      return 4'd4;
        endcase
    endfunction

    // Number of rounds for a key mode.
    function automatic logic [3:0] nr_of(input logic [1:0] mode);
        case (mode)
            KEY_MODE_128: return 4'd10;
            KEY_MODE_192: return 4'd12;
            KEY_MODE_256: return 4'd14;
            default:      return 4'd10;
        endcase
    endfunction

    // Multiply by x in GF(2^8), reduction polynomial 0x11b.
    function automatic logic [7:0] xtime(input logic [7:0] b);
        return {b[6:0], 1'b0} ^ (b[7] ? 8'h1b : 8'h00);
    endfunction

    // General GF(2^8) multiply by shift-and-add.
    function automatic logic [7:0] gf_mul(input logic [7:0] a, input logic [7:0] b);
        logic [7:0] acc;
        logic [7:0] sh;
        acc = 8'h00;
        sh  = a;
        for (int i = 0; i < 8; i++) begin
            if (b[i]) acc = acc ^ sh;
            sh = xtime(sh);
        end
        return acc;
    endfunction

    // AES S-box computed as x^254 (multiplicative inverse, 0 -> 0) then the affine map.
    function automatic logic [7:0] sbox(input logic [7:0] x);
        logic [7:0] p;
        logic [7:0] inv;
        p   = x;
        inv = 8'h01;
        for (int k = 1; k < 8; k++) begin
            p   = gf_mul(p, p);
            inv = gf_mul(inv, p);
        end
        return inv ^ {inv[6:0], inv[7]} ^ {inv[5:0], inv[7:6]}
                   ^ {inv[4:0], inv[7:5]} ^ {inv[3:0], inv[7:4]} ^ 8'h63;
    endfunction

    // S-box applied to each byte of a word.
    function automatic logic [31:0] sub_word(input logic [31:0] w);
        return {sbox(w[31:24]), sbox(w[23:16]), sbox(w[15:8]), sbox(w[7:0])};
    endfunction

endpackage

// File: rtl/key_expansion_word_lane.sv
// One key-schedule word: pass-through of a key word, or the
// RotWord/SubWord/Rcon/XOR combination against w[i-1] and w[i-Nk].
module key_expansion_word_lane
    import aes_key_sched_pkg::*;
(
    input  logic [31:0] key_word_i,
    input  logic [31:0] prev_word_i,
    input  logic [31:0] back_word_i,
    input  logic        use_key_i,
    input  logic        rot_sub_i,
    input  logic        sub_only_i,
    input  logic [7:0]  rcon_i,
    output logic [31:0] word_o
);

    logic [31:0] rot_s;

    assign rot_s = {prev_word_i[23:0], prev_word_i[31:24]};

    // Select the word recurrence that applies to this index position.
    always_comb begin
        word_o = 32'h0000_0000;
        if (use_key_i) begin
            word_o = key_word_i;
        end else if (rot_sub_i) begin
            word_o = sub_word(rot_s) ^ {rcon_i, 24'h00_0000} ^ back_word_i;
        end else if (sub_only_i) begin
            word_o = sub_word(prev_word_i) ^ back_word_i;
        end else begin
            word_o = prev_word_i ^ back_word_i;
        end
    end

endmodule

// File: rtl/key_expansion_engine_nwords.sv
// AES-128/192/256 key expansion streaming N_WORDS words per valid/ready beat.
// Optional output o_last_key is built when KEY_EXPANSION_LAST_KEY_OUT_EN is defined.
module key_expansion_engine_nwords
    import aes_key_sched_pkg::*;
#(
    parameter int N_WORDS      = 4,
    parameter int NB_BYTE      = 8,
    parameter int N_BYTES_WORD = 4,
    parameter int NB_WORD      = N_BYTES_WORD * NB_BYTE,
    parameter int MAX_NK       = 8,
    parameter int NB_INDEX     = 6
)
(
    input  logic                        i_clock,
    input  logic                        i_reset_n,
    input  logic [MAX_NK*NB_WORD-1:0]   i_key,
    input  logic [1:0]                  i_key_mode,
    input  logic                        i_start,
    output logic                        o_ready,
    output logic                        o_key_valid,
    input  logic                        i_key_ready,
    output logic [N_WORDS*NB_WORD-1:0]  o_key_words,
    output logic [NB_INDEX-1:0]         o_word_index,
    output logic                        o_done,
    output logic                        o_mode_error
`ifdef KEY_EXPANSION_LAST_KEY_OUT_EN
    ,
    output logic [MAX_NK*NB_WORD-1:0]   o_last_key
`endif
);

    if (!(N_WORDS == 1 || N_WORDS == 2 || N_WORDS == 4) || NB_WORD != 32 || MAX_NK != 8) begin : g_bad_params
        $error("key_expansion_engine_nwords: N_WORDS must be 1, 2 or 4 with 32-bit words and MAX_NK 8");
    end

    state_e                       state_q, state_d;
    logic [NB_WORD-1:0]           key_q [MAX_NK];
    logic [NB_WORD-1:0]           key_d [MAX_NK];
    logic [NB_WORD-1:0]           win_q [MAX_NK];
    logic [NB_WORD-1:0]           win_d [MAX_NK];
    logic [NB_WORD-1:0]           win_shift_s [MAX_NK];
    logic [3:0]                   nk_q, nk_d;
    logic [NB_INDEX-1:0]          last_idx_q, last_idx_d;
    logic [NB_INDEX-1:0]          idx_q, idx_d;
    logic [NB_INDEX-1:0]          idx_next_s;
    logic [4*N_WORDS-1:0]         pos_q, pos_d, pos_adv_s;
    logic [7:0]                   rcon_q, rcon_d;
    logic                         valid_q, valid_d;
    logic [N_WORDS*NB_WORD-1:0]   words_q, words_d, beat_s;
    logic                         done_q, done_d;
    logic                         merr_q, merr_d;
    logic [N_WORDS-1:0]           rot_vec_s;
    logic                         hs_s;

    assign hs_s       = valid_q & i_key_ready;
    assign idx_next_s = idx_q + NB_INDEX'(N_WORDS);

    // Window as it will look after the current beat is accepted (oldest at 0).
    always_comb begin
        for (int k = 0; k < MAX_NK; k++) begin
            if (k < MAX_NK - N_WORDS) begin
                win_shift_s[k] = win_q[k + N_WORDS];
            end else begin
                win_shift_s[k] = words_q[NB_WORD*(MAX_NK-1-k) +: NB_WORD];
            end
        end
    end

    for (genvar j = 0; j < N_WORDS; j++) begin : g_lane
        logic [NB_INDEX-1:0] widx_s;
        logic [4:0]          pos_sum_s;
        logic [4:0]          pos_wrap_s;
        logic [3:0]          pos_s;
        logic [3:0]          back_idx_s;
        logic                use_key_s;
        logic                rot_sub_s;
        logic                sub_only_s;
        logic [NB_WORD-1:0]  prev_s;
        logic [NB_WORD-1:0]  word_s;

        assign widx_s     = idx_next_s + NB_INDEX'(j);
        assign use_key_s  = (widx_s < NB_INDEX'(nk_q));
        assign back_idx_s = 4'(MAX_NK + j) - nk_q;

        // Advance this lane's word position modulo Nk by one beat.
        always_comb begin
            pos_sum_s = {1'b0, pos_q[4*j +: 4]} + 5'(N_WORDS);
            if (pos_sum_s >= {1'b0, nk_q}) begin
                pos_wrap_s = pos_sum_s - {1'b0, nk_q};
            end else begin
                pos_wrap_s = pos_sum_s;
            end
        end

        assign pos_s      = pos_wrap_s[3:0];
        assign rot_sub_s  = !use_key_s && (pos_s == 4'd0);
        assign sub_only_s = !use_key_s && (nk_q == 4'd8) && (pos_s == 4'd4);

        if (j == 0) begin : g_head
            assign prev_s = win_shift_s[MAX_NK-1];
        end else begin : g_chain
            assign prev_s = g_lane[j-1].word_s;
        end

        key_expansion_word_lane u_lane (
            .key_word_i  (key_q[widx_s[2:0]]),
            .prev_word_i (prev_s),
            .back_word_i (win_shift_s[back_idx_s[2:0]]),
            .use_key_i   (use_key_s),
            .rot_sub_i   (rot_sub_s),
            .sub_only_i  (sub_only_s),
            .rcon_i      (rcon_q),
            .word_o      (word_s)
        );

        assign beat_s[NB_WORD*(N_WORDS-1-j) +: NB_WORD] = word_s;
        assign pos_adv_s[4*j +: 4] = pos_s;
        assign rot_vec_s[j]        = rot_sub_s;
    end

    // Next-state and datapath updates: latch on start, step the window on each handshake.
    always_comb begin
        state_d    = state_q;
        nk_d       = nk_q;
        last_idx_d = last_idx_q;
        idx_d      = idx_q;
        pos_d      = pos_q;
        rcon_d     = rcon_q;
        valid_d    = valid_q;
        words_d    = words_q;
        done_d     = 1'b0;
        merr_d     = 1'b0;
        for (int k = 0; k < MAX_NK; k++) begin
            key_d[k] = key_q[k];
            win_d[k] = win_q[k];
        end
        case (state_q)
            ST_IDLE: begin
                if (i_start && (i_key_mode != KEY_MODE_ILLEGAL)) begin
                    state_d    = ST_RUN;
                    nk_d       = nk_of(i_key_mode);
                    last_idx_d = NB_INDEX'(4 * (int'(nr_of(i_key_mode)) + 1) - N_WORDS);
                    idx_d      = {NB_INDEX{1'b0}};
                    rcon_d     = RCON_INIT;
                    valid_d    = 1'b1;
                    words_d    = i_key[MAX_NK*NB_WORD-1 -: N_WORDS*NB_WORD];
                    for (int j = 0; j < N_WORDS; j++) begin
                        pos_d[4*j +: 4] = 4'(j);
                    end
                    for (int k = 0; k < MAX_NK; k++) begin
                        key_d[k] = i_key[NB_WORD*(MAX_NK-1-k) +: NB_WORD];
                        win_d[k] = {NB_WORD{1'b0}};
                    end
                end else if (i_start) begin
                    merr_d = 1'b1;
                end else begin
                    state_d = ST_IDLE;
                end
            end
            ST_RUN: begin
                if (hs_s) begin
                    for (int k = 0; k < MAX_NK; k++) begin
                        win_d[k] = win_shift_s[k];
                    end
                    if (idx_q == last_idx_q) begin
                        state_d = ST_IDLE;
                        valid_d = 1'b0;
                        done_d  = 1'b1;
                    end else begin
                        idx_d   = idx_next_s;
                        pos_d   = pos_adv_s;
                        words_d = beat_s;
                        rcon_d  = (|rot_vec_s) ? xtime(rcon_q) : rcon_q;
                    end
                end else begin
                    state_d = ST_RUN;
                end
            end
            default: begin
                state_d = ST_IDLE;
                valid_d = 1'b0;
            end
        endcase
    end

    // State register plus all datapath registers, cleared by the asynchronous reset.
    always_ff @(posedge i_clock or negedge i_reset_n) begin
        if (!i_reset_n) begin
            state_q    <= ST_IDLE;
            nk_q       <= 4'd4;
            last_idx_q <= {NB_INDEX{1'b0}};
            idx_q      <= {NB_INDEX{1'b0}};
            pos_q      <= {(4*N_WORDS){1'b0}};
            rcon_q     <= 8'h00;
            valid_q    <= 1'b0;
            words_q    <= {(N_WORDS*NB_WORD){1'b0}};
            done_q     <= 1'b0;
            merr_q     <= 1'b0;
            for (int k = 0; k < MAX_NK; k++) begin
                key_q[k] <= {NB_WORD{1'b0}};
                win_q[k] <= {NB_WORD{1'b0}};
            end
        end else begin
            state_q    <= state_d;
            nk_q       <= nk_d;
            last_idx_q <= last_idx_d;
            idx_q      <= idx_d;
            pos_q      <= pos_d;
            rcon_q     <= rcon_d;
            valid_q    <= valid_d;
            words_q    <= words_d;
            done_q     <= done_d;
            merr_q     <= merr_d;
            for (int k = 0; k < MAX_NK; k++) begin
                key_q[k] <= key_d[k];
                win_q[k] <= win_d[k];
            end
        end
    end

    assign o_ready      = (state_q == ST_IDLE);
    assign o_key_valid  = valid_q;
    assign o_key_words  = words_q;
    assign o_word_index = idx_q;
    assign o_done       = done_q;
    assign o_mode_error = merr_q;

`ifdef KEY_EXPANSION_LAST_KEY_OUT_EN
    logic [MAX_NK*NB_WORD-1:0] last_key_q, last_key_d;
    logic [3:0]                lk_idx_s;

    // Final Nk words of the window, left-aligned, captured on the final handshake.
    always_comb begin
        last_key_d = last_key_q;
        lk_idx_s   = 4'd0;
        if ((state_q == ST_IDLE) && i_start && (i_key_mode != KEY_MODE_ILLEGAL)) begin
            last_key_d = {(MAX_NK*NB_WORD){1'b0}};
        end else if ((state_q == ST_RUN) && hs_s && (idx_q == last_idx_q)) begin
            for (int k = 0; k < MAX_NK; k++) begin
                lk_idx_s = 4'(MAX_NK + k) - nk_q;
                if (4'(k) < nk_q) begin
                    last_key_d[NB_WORD*(MAX_NK-1-k) +: NB_WORD] = win_shift_s[lk_idx_s[2:0]];
                end else begin
                    last_key_d[NB_WORD*(MAX_NK-1-k) +: NB_WORD] = {NB_WORD{1'b0}};
                end
            end
        end else begin
            last_key_d = last_key_q;
        end
    end

    // Last-key register, held until the next accepted start or reset.
    always_ff @(posedge i_clock or negedge i_reset_n) begin
        if (!i_reset_n) begin
            last_key_q <= {(MAX_NK*NB_WORD){1'b0}};
        end else begin
            last_key_q <= last_key_d;
        end
    end

    assign o_last_key = last_key_q;
`endif

endmodule

// File: tb/tb_key_expansion_engine_nwords.sv
// Directed bench for key_expansion_engine_nwords (N_WORDS=4) using FIPS-197 A.1-A.3 vectors.
module tb_key_expansion_engine_nwords;

    logic         clk;
    logic         rst_n;
    logic [255:0] key;
    logic [1:0]   key_mode;
    logic         start;
    logic         ready;
    logic         key_valid;
    logic         key_ready;
    logic [127:0] key_words;
    logic [5:0]   word_index;
    logic         done;
    logic         mode_error;

    int n_checks;
    int n_pass;

    logic [31:0] got    [0:59];
    logic [31:0] ref192 [0:59];

    localparam logic [255:0] KEY128 = {128'h2b7e151628aed2a6abf7158809cf4f3c, 128'h0};
    localparam logic [255:0] KEY192 = {192'h8e73b0f7da0e6452c810f32b809079e562f8ead2522c6b7b, 64'h0};
    localparam logic [255:0] KEY256 = 256'h603deb1015ca71be2b73aef0857d77811f352c073b6108d72d9810a30914dff4;

    key_expansion_engine_nwords dut (
        .i_clock      (clk),
        .i_reset_n    (rst_n),
        .i_key        (key),
        .i_key_mode   (key_mode),
        .i_start      (start),
        .o_ready      (ready),
        .o_key_valid  (key_valid),
        .i_key_ready  (key_ready),
        .o_key_words  (key_words),
        .o_word_index (word_index),
        .o_done       (done),
        .o_mode_error (mode_error)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [127:0] obs, input logic [127:0] exp);
        n_checks++;
        if (obs !== exp) begin
            $display("FAIL %s: got %h expected %h", tag, obs, exp);
        end else begin
            n_pass++;
        end
    endtask

    // Runs one key through the engine from IDLE, recording words by expected beat position.
    task automatic run_stream(input logic [1:0] mode, input logic [255:0] kin, input int exp_beats,
                              input bit stall, input int inject_at, input int reset_at);
        int           beats;
        bit           stalled;
        bit           fin;
        bit           last_beat;
        bit           rdy;
        logic [127:0] held_w;
        logic [5:0]   held_i;
        beats     = 0;
        stalled   = 1'b0;
        fin       = 1'b0;
        last_beat = 1'b0;
        held_w    = 128'h0;
        held_i    = 6'd0;
        for (int k = 0; k < 60; k++) got[k] = 32'h0;
        key_mode = mode;
        key      = kin;
        start    = 1'b1;
        @(negedge clk);
        start = 1'b0;
        check("start_latency", 128'(key_valid), 128'd1);
        check("busy_not_ready", 128'(ready), 128'd0);
        for (int cyc = 0; cyc < 400 && !fin; cyc++) begin
            start    = 1'b0;
            key_mode = mode;
            key      = kin;
            if (stalled) begin
                check("stall_words", key_words, held_w);
                check("stall_index", 128'(word_index), 128'(held_i));
                stalled = 1'b0;
            end
            if (reset_at >= 0 && beats == reset_at) begin
                rst_n = 1'b0;
                #1;
                check("rst_words", key_words, 128'h0);
                check("rst_index", 128'(word_index), 128'd0);
                check("rst_valid", 128'(key_valid), 128'd0);
                check("rst_ready", 128'(ready), 128'd1);
                check("rst_done", 128'(done), 128'd0);
                fin = 1'b1;
            end else begin
                if (beats == inject_at) begin
                    start    = 1'b1;
                    key_mode = 2'd2;
                    key      = 256'h0;
                end
                rdy = stall ? ($urandom_range(0, 2) != 0) : 1'b1;
                key_ready = rdy;
                check("valid_held", 128'(key_valid), 128'd1);
                if (key_valid && rdy) begin
                    check("word_index", 128'(word_index), 128'(beats * 4));
                    check("done_early", 128'(done), 128'd0);
                    if (beats < 15) begin
                        for (int j = 0; j < 4; j++) got[beats*4 + j] = key_words[127 - 32*j -: 32];
                    end
                    beats++;
                    if (beats == exp_beats) last_beat = 1'b1;
                end else begin
                    stalled = 1'b1;
                    held_w  = key_words;
                    held_i  = word_index;
                end
                @(negedge clk);
                if (last_beat) begin
                    start = 1'b0;
                    check("done_pulse", 128'(done), 128'd1);
                    check("done_ready", 128'(ready), 128'd1);
                    check("done_valid", 128'(key_valid), 128'd0);
                    @(negedge clk);
                    check("done_one_cycle", 128'(done), 128'd0);
                    fin = 1'b1;
                end
            end
        end
        start     = 1'b0;
        key_ready = 1'b0;
        if (!fin) check("stream_timeout", 128'd0, 128'd1);
    endtask

    initial begin
        n_checks  = 0;
        n_pass    = 0;
        rst_n     = 1'b0;
        start     = 1'b0;
        key_ready = 1'b0;
        key_mode  = 2'd0;
        key       = 256'h0;
        repeat (2) @(negedge clk);
        check("reset_ready", 128'(ready), 128'd1);
        check("reset_valid", 128'(key_valid), 128'd0);
        check("reset_words", key_words, 128'h0);
        check("reset_index", 128'(word_index), 128'd0);
        check("reset_done", 128'(done), 128'd0);
        check("reset_merr", 128'(mode_error), 128'd0);
        rst_n = 1'b1;
        @(negedge clk);

        // AES-128, no backpressure.
        run_stream(2'd0, KEY128, 11, 1'b0, -1, -1);
        check("a1_w0", 128'(got[0]), 128'h2b7e1516);
        check("a1_w3", 128'(got[3]), 128'h09cf4f3c);
        check("a1_w4", 128'(got[4]), 128'ha0fafe17);
        check("a1_w5", 128'(got[5]), 128'h88542cb1);
        check("a1_w6", 128'(got[6]), 128'h23a33939);
        check("a1_w7", 128'(got[7]), 128'h2a6c7605);
        check("a1_w40", 128'(got[40]), 128'hd014f9a8);
        check("a1_w41", 128'(got[41]), 128'hc9ee2589);
        check("a1_w42", 128'(got[42]), 128'he13f0cc8);
        check("a1_w43", 128'(got[43]), 128'hb6630ca6);

        // AES-192, no backpressure; kept as the reference for the stalled run.
        run_stream(2'd1, KEY192, 13, 1'b0, -1, -1);
        check("a2_w0", 128'(got[0]), 128'h8e73b0f7);
        check("a2_w5", 128'(got[5]), 128'h522c6b7b);
        check("a2_w6", 128'(got[6]), 128'hfe0c91f7);
        check("a2_w51", 128'(got[51]), 128'h01002202);
        for (int k = 0; k < 60; k++) ref192[k] = got[k];

        // AES-192 with random stalls must give the same stream.
        run_stream(2'd1, KEY192, 13, 1'b1, -1, -1);
        check("a2s_w6", 128'(got[6]), 128'hfe0c91f7);
        check("a2s_w51", 128'(got[51]), 128'h01002202);
        for (int k = 0; k < 52; k++) check("a2_stall_stream", 128'(got[k]), 128'(ref192[k]));

        // AES-256.
        run_stream(2'd2, KEY256, 15, 1'b0, -1, -1);
        check("a3_w7", 128'(got[7]), 128'h0914dff4);
        check("a3_w8", 128'(got[8]), 128'h9ba35411);
        check("a3_w59", 128'(got[59]), 128'h706c631e);

        // Mid-stream start must not disturb the AES-128 stream.
        run_stream(2'd0, KEY128, 11, 1'b0, 3, -1);
        check("inj_w4", 128'(got[4]), 128'ha0fafe17);
        check("inj_w43", 128'(got[43]), 128'hb6630ca6);

        // Illegal mode in IDLE.
        key_mode = 2'd3;
        start    = 1'b1;
        @(negedge clk);
        start = 1'b0;
        check("merr_pulse", 128'(mode_error), 128'd1);
        check("merr_ready", 128'(ready), 128'd1);
        check("merr_valid", 128'(key_valid), 128'd0);
        @(negedge clk);
        check("merr_one_cycle", 128'(mode_error), 128'd0);
        check("merr_still_ready", 128'(ready), 128'd1);

        // Reset at beat 5 of AES-256, then a clean AES-128 run.
        run_stream(2'd2, KEY256, 15, 1'b0, -1, 5);
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        run_stream(2'd0, KEY128, 11, 1'b0, -1, -1);
        check("post_rst_w0", 128'(got[0]), 128'h2b7e1516);
        check("post_rst_w4", 128'(got[4]), 128'ha0fafe17);
        check("post_rst_w43", 128'(got[43]), 128'hb6630ca6);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
